aurora_20g_adc_gen: RTL and testbench

Test-pattern source for the 20G Aurora ADC data path. It produces the incrementing 16-bit lane pattern that the downstream ADC pattern checker expects, so the link can be validated end to end without live ADC samples. It sits in place of the ADC packer, directly upstream of the Aurora TX FIFO or the checker. Bursts, inter-beat gaps and downstream backpressure are all controlled at run time.

---
 rtl/aurora_20g_adc_gen.sv | 139 +++++++++++++
 tb/tb_aurora_20g_adc_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/aurora_20g_adc_gen.sv
// Incrementing 16-bit lane test-pattern source for the 20G Aurora ADC path.
// Optional corrupted-beat injection is built when AURORA_ADC_GEN_ERR_INJ_EN is defined.
module aurora_20g_adc_gen #(
  parameter int DATA_WD = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_rst,
  input  logic               cfg_en,
  input  logic [15:0]        cfg_len,
  input  logic [7:0]         cfg_gap,
  input  logic               cfg_err_inj,
  input  logic               adc_rdy,
  output logic               adc_vld,
  output logic [DATA_WD-1:0] adc_data,
  output logic [31:0]        tx_cnt,
  output logic               busy
);
  localparam int LANES = DATA_WD / 16;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        base_q, base_d, len_q, len_d, beat_q, beat_d;
  logic [1:0]         ph_q, ph_d;
  logic [7:0]         gap_q, gap_d, gcnt_q, gcnt_d;
  logic [31:0]        tx_q, tx_d;
  logic               vld_q, busy_q;
  logic [DATA_WD-1:0] data_q, data_d, pat;
  logic               acc, load, flip;

  // Lane i carries base + (i mod 4); the pattern follows the next-state base
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign pat[16*i +: 16] = base_d + 16'(i % 4);
  end

  assign acc  = vld_q & adc_rdy;
  // A fresh beat is loaded on entry to SEND or after an acceptance; stalls hold data
  assign load = (state_d == SEND) && ((state_q != SEND) || acc);

`ifdef AURORA_ADC_GEN_ERR_INJ_EN
  logic pend_q, pend_any;
  assign pend_any = pend_q | cfg_err_inj;
  assign flip     = load & pend_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pend_q <= 1'b0;
    else if (cfg_rst) pend_q <= 1'b0;
    else              pend_q <= pend_any & ~load;
  end
`else
  logic unused_err_inj;
  assign unused_err_inj = cfg_err_inj;
  assign flip           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ph_d    = ph_q;
    len_d   = len_q;
    gap_d   = gap_q;
    beat_d  = beat_q;
    gcnt_d  = gcnt_q;
    tx_d    = tx_q;
    if (acc) begin
      ph_d   = ph_q + 2'd1;
      beat_d = beat_q + 16'd1;
      if (ph_q == 2'd3)  base_d = base_q + 16'd4;
      if (tx_q != '1)    tx_d   = tx_q + 32'd1;
    end
    case (state_q)
      IDLE: if (cfg_en) begin
        state_d = SEND;
        len_d   = cfg_len;
        gap_d   = cfg_gap;
        beat_d  = '0;
      end
      SEND: if (acc) begin
        if ((len_q != '0) && (beat_q + 16'd1 == len_q)) state_d = DONE;
        else if (!cfg_en)                               state_d = IDLE;
        else if (gap_q != '0) begin
          state_d = GAP;
          gcnt_d  = gap_q;
        end
      end
      GAP: begin
        if (gcnt_q <= 8'd1) state_d = cfg_en ? SEND : IDLE;
        else                gcnt_d  = gcnt_q - 8'd1;
      end
      DONE: if (!cfg_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_d = load ? (pat ^ {{(DATA_WD-1){1'b0}}, flip}) : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      ph_q    <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      beat_q  <= '0;
      gcnt_q  <= '0;
      tx_q    <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else if (cfg_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      ph_q    <= '0;
      beat_q  <= '0;
      gcnt_q  <= '0;
      tx_q    <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ph_q    <= ph_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
      gcnt_q  <= gcnt_d;
      tx_q    <= tx_d;
      vld_q   <= (state_d == SEND);
      busy_q  <= (state_d == SEND) || (state_d == GAP);
      data_q  <= data_d;
    end
  end

  assign adc_vld  = vld_q;
  assign adc_data = data_q;
  assign tx_cnt   = tx_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_aurora_20g_adc_gen.sv
// Bench for aurora_20g_adc_gen: directed steps plus random backpressure against a beat-index model.
module tb_aurora_20g_adc_gen;
  localparam int DW = 128;
  localparam logic [127:0] C0    = 128'h0003_0002_0001_0000_0003_0002_0001_0000;
  localparam logic [127:0] C4    = 128'h0007_0006_0005_0004_0007_0006_0005_0004;
  localparam logic [127:0] CFFFC = 128'hffff_fffe_fffd_fffc_ffff_fffe_fffd_fffc;

  logic          clk = 1'b0, rst_n = 1'b0, cfg_rst = 1'b0, cfg_en = 1'b0;
  logic          cfg_err_inj = 1'b0, adc_rdy = 1'b0;
  logic [15:0]   cfg_len = '0;
  logic [7:0]    cfg_gap = '0;
  logic          adc_vld, busy;
  logic [DW-1:0] adc_data;
  logic [31:0]   tx_cnt;

  int checks = 0, fails = 0;
  int unsigned k = 0;
  int exp_flips = 0, seen_flips = 0;
  bit pend = 0, prev_vld = 0, prev_rdy = 0, prev_rst = 0;
  logic [DW-1:0] prev_data = '0, e_beat;
  logic [15:0] vpat;

  aurora_20g_adc_gen #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_en(cfg_en),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_err_inj(cfg_err_inj),
    .adc_rdy(adc_rdy), .adc_vld(adc_vld), .adc_data(adc_data),
    .tx_cnt(tx_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // The n-th accepted beat since reset carries base = 4*floor(n/4) in every 4-lane group
  function automatic logic [DW-1:0] beat_of(input int unsigned n);
    logic [DW-1:0] v;
    logic [15:0]   b;
    b = 16'(4 * (n / 4));
    for (int i = 0; i < DW/16; i++) v[16*i +: 16] = b + 16'(i % 4);
    return v;
  endfunction

  // Scoreboard: sampled on the falling edge, inputs only change just after rising edges
  always @(negedge clk) begin
    if (!rst_n) begin
      k = 0; pend = 0; prev_vld = 0;
    end else begin
      chk("tx_cnt", tx_cnt, k);
      if (prev_vld && !prev_rdy && !prev_rst) begin
        chk("stall_vld", adc_vld, 1);
        chk("stall_data", adc_data, prev_data);
      end
      if (cfg_rst) begin
        k = 0; pend = 0;
      end else begin
        if (adc_vld && adc_rdy) begin
          e_beat = beat_of(k);
          if (pend) begin e_beat[0] = ~e_beat[0]; pend = 0; exp_flips++; end
          if (adc_data !== beat_of(k)) seen_flips++;
          chk("beat_data", adc_data, e_beat);
          k++;
        end
`ifdef AURORA_ADC_GEN_ERR_INJ_EN
        if (cfg_err_inj) pend = 1;
`endif
      end
      prev_vld = adc_vld; prev_rdy = adc_rdy; prev_rst = cfg_rst; prev_data = adc_data;
    end
  end

  initial begin
    // reset values
    @(negedge clk);
    chk("rst_vld", adc_vld, 0);
    chk("rst_data", adc_data, 0);
    chk("rst_tx", tx_cnt, 0);
    chk("rst_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;

    // continuous, 8 beats
    adc_rdy = 1'b1;
    tick(1);
    cfg_en = 1'b1;
    @(negedge clk);
    chk("cont_lat_vld", adc_vld, 0);
    @(posedge clk); @(negedge clk);
    chk("cont_first_vld", adc_vld, 1);
    chk("cont_first_data", adc_data, C0);
    chk("cont_busy", busy, 1);
    repeat (7) @(posedge clk);
    #1 cfg_en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("cont_end_vld", adc_vld, 0);
    chk("cont_end_tx", tx_cnt, 8);
    chk("cont_end_busy", busy, 0);

    // burst len=5 gap=2; config changed mid-burst must not matter
    tick(1); cfg_rst = 1'b1;
    tick(1); cfg_rst = 1'b0;
    cfg_len = 16'd5; cfg_gap = 8'd2; cfg_en = 1'b1;
    @(posedge clk);
    vpat = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vpat[i] = adc_vld;
      if (i == 0) begin cfg_len = 16'd0; cfg_gap = 8'd0; end
    end
    chk("burst_vld_pattern", vpat, 16'h1249);
    chk("burst_tx", tx_cnt, 5);
    chk("burst_done_busy", busy, 0);
    tick(1); cfg_en = 1'b0;
    tick(1); cfg_en = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("resume_vld", adc_vld, 1);
    chk("resume_data", adc_data, C4);
    cfg_en = 1'b0;
    tick(3);

    // random backpressure, enable toggling and reconfiguration
    cfg_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick(1);
      adc_rdy = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 31);
      if (r == 0)     cfg_en = 1'b0;
      else if (r < 8) cfg_en = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        cfg_len = 16'($urandom_range(0, 6));
        cfg_gap = 8'($urandom_range(0, 3));
      end
    end
    cfg_en = 1'b0; adc_rdy = 1'b1; cfg_len = '0; cfg_gap = '0;
    begin
      int w = 0;
      while ((busy || adc_vld) && w < 300) begin tick(1); w++; end
      if (busy || adc_vld) begin fails++; $error("FAIL bp_drain: observed busy after %0d cycles", w); end
    end

    // error injection pulse while idle, then continuous run
    tick(1); cfg_rst = 1'b1;
    tick(1); cfg_rst = 1'b0;
    cfg_err_inj = 1'b1;
    tick(1); cfg_err_inj = 1'b0; cfg_en = 1'b1;
    tick(8); cfg_en = 1'b0;
    tick(3);
`ifdef AURORA_ADC_GEN_ERR_INJ_EN
    chk("inj_flips", seen_flips, 1);
`else
    chk("inj_flips", seen_flips, 0);
`endif
    chk("inj_model_flips", seen_flips, exp_flips);

    // cfg_rst during SEND, then async rst_n
    cfg_en = 1'b1;
    tick(5); cfg_rst = 1'b1;
    @(posedge clk); #1 cfg_rst = 1'b0;
    @(negedge clk);
    chk("crst_vld", adc_vld, 0);
    chk("crst_tx", tx_cnt, 0);
    @(posedge clk); @(negedge clk);
    chk("crst_restart_vld", adc_vld, 1);
    chk("crst_restart_data", adc_data, C0);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", adc_vld, 0);
    chk("arst_tx", tx_cnt, 0);
    chk("arst_data", adc_data, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("arst_restart_vld", adc_vld, 1);
    chk("arst_restart_data", adc_data, C0);
    cfg_en = 1'b0;
    tick(3);

    // base wrap across 0xFFFC
    cfg_rst = 1'b1;
    tick(1); cfg_rst = 1'b0; cfg_en = 1'b1;
    begin
      int c = 0;
      while (tx_cnt != 32'd65532 && c < 70000) begin @(negedge clk); c++; end
      if (tx_cnt != 32'd65532) begin fails++; $error("FAIL wrap_wait1: observed tx_cnt %0d", tx_cnt); end
      else chk("wrap_fffc_data", adc_data, CFFFC);
      c = 0;
      while (tx_cnt != 32'd65536 && c < 100) begin @(negedge clk); c++; end
      if (tx_cnt != 32'd65536) begin fails++; $error("FAIL wrap_wait2: observed tx_cnt %0d", tx_cnt); end
      else begin
        chk("wrap_0000_data", adc_data, C0);
        chk("wrap_vld", adc_vld, 1);
      end
    end
    tick(1); cfg_en = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
